// File: rtl/tone_detector_if.sv
// Tone detector signal bundle: tone input plus recovered-count results.
// master = tone source / result consumer, slave = the detector itself.
`timescale 1ns/1ps
interface tone_detector_if #(
    parameter int WIDTH = 16
);
    logic             tone_in;
    logic [WIDTH-1:0] maxcount;
    logic             valid;
    logic             new_sample;
    logic             silent;

    modport master (
        output tone_in,
        input  maxcount,
        input  valid,
        input  new_sample,
        input  silent
    );

    modport slave (
        input  tone_in,
        output maxcount,
        output valid,
        output new_sample,
        output silent
    );
endinterface

// File: rtl/tone_detector.sv
// Measures the half-period of a square-wave tone and reports it as a divider terminal count.
// Optional macro TONE_DETECTOR_AVG_EN: report the mean of the two latest half-periods.
`timescale 1ns/1ps
module tone_detector #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 2
) (
    input  logic            clk,
    input  logic            rst,
    tone_detector_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRACK, S_LOCKED} state_t;

    localparam int              SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOL);

    logic [SYNC_N-1:0] r_sync;
    logic              r_hist;
    logic [WIDTH-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_last;
    logic [WIDTH-1:0]  r_maxcount;
    state_t            r_state;
    logic              r_valid;
    logic              r_new_sample;
    logic              r_silent;

    logic              w_edge;
    logic              w_agree;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH-1:0]  w_sample;
`ifdef TONE_DETECTOR_AVG_EN
    logic [WIDTH:0]    w_sum;
`endif

    // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], bus.tone_in};
            r_hist <= r_sync[SYNC_N-1];
        end
    end

    assign w_edge = r_sync[SYNC_N-1] ^ r_hist;

    // Half-period counter: restarts after each edge, sticks at all-ones when the tone stops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
    always_comb begin
        w_diff  = (r_cnt >= r_last) ? ({1'b0, r_cnt} - {1'b0, r_last})
                                    : ({1'b0, r_last} - {1'b0, r_cnt});
        w_agree = (w_diff <= TOL_W);
`ifdef TONE_DETECTOR_AVG_EN
        w_sum    = {1'b0, r_cnt} + {1'b0, r_last};
        w_sample = w_sum[WIDTH:1];
`else
        w_sample = r_cnt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last       <= '0;
            r_maxcount   <= '0;
            r_valid      <= 1'b0;
            r_new_sample <= 1'b0;
            r_silent     <= 1'b1;
        end else begin
            r_new_sample <= 1'b0;
            if (w_edge) begin
                r_last <= r_cnt;
                // An edge after a saturated count restarts acquisition as if from IDLE.
                if (r_state == S_IDLE || r_cnt == CNT_MAX) begin
                    r_state    <= S_ARMED;
                    r_silent   <= 1'b0;
                    r_valid    <= 1'b0;
                    r_maxcount <= '0;
                end else begin
                    case (r_state)
                        S_ARMED: r_state <= S_TRACK;
                        S_TRACK: begin
                            if (w_agree) begin
                                r_state      <= S_LOCKED;
                                r_valid      <= 1'b1;
                                r_maxcount   <= w_sample;
                                r_new_sample <= ~r_new_sample;
                            end
                        end
                        S_LOCKED: begin
                            if (w_agree) begin
                                r_maxcount   <= w_sample;
                                r_new_sample <= ~r_new_sample;
                            end else begin
                                r_state <= S_TRACK;
                                r_valid <= 1'b0;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end else if (r_cnt == CNT_MAX && r_state != S_IDLE) begin
                r_state    <= S_IDLE;
                r_valid    <= 1'b0;
                r_silent   <= 1'b1;
                r_maxcount <= '0;
            end
        end
    end

    assign bus.maxcount   = r_maxcount;
    assign bus.valid      = r_valid;
    assign bus.new_sample = r_new_sample;
    assign bus.silent     = r_silent;
endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector: a half-period model predicts each new_sample
// and its maxcount; spot checks cover reset, unlock, and silence timeout.
`timescale 1ns/1ps
module tb_tone_detector;
    localparam int WIDTH = 16;
    localparam int TOL   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_detector_if #(.WIDTH(WIDTH)) bus ();

    tone_detector #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .TOL         (TOL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {M_IDLE, M_ARMED, M_TRACK, M_LOCKED} m_state_t;

    m_state_t m_state = M_IDLE;
    int       m_last  = 0;
    int       sb_q[$];
    int       n_checks = 0;
    int       n_errors = 0;

    logic prev_ns     = 1'b0;
    bit   watch_hold  = 1'b0;
    bit   watch_low   = 1'b0;
    int   valid_drops = 0;
    int   valid_highs = 0;
    int   exp_mc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model works on driven half-periods, not on DUT internals.
    task automatic model_edge(input int half);
        int c;
        int d;
        c = half - 1;
        case (m_state)
            M_IDLE:  m_state = M_ARMED;
            M_ARMED: m_state = M_TRACK;
            default: begin
                d = (c > m_last) ? (c - m_last) : (m_last - c);
                if (d <= TOL) begin
                    m_state = M_LOCKED;
`ifdef TONE_DETECTOR_AVG_EN
                    sb_q.push_back((c + m_last) / 2);
`else
                    sb_q.push_back(c);
`endif
                end else begin
                    m_state = M_TRACK;
                end
            end
        endcase
        m_last = c;
    endtask

    // Toggle tone_in so the interval since the previous toggle is 'half' cycles;
    // 'already' is how many of those cycles the caller has already waited.
    task automatic toggle(input int half, input int already);
        repeat (half - already) @(negedge clk);
        bus.tone_in = ~bus.tone_in;
        model_edge(half);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        m_state = M_IDLE;
        m_last  = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tone_in = 1'b0;
        reset_model();
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(5);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_maxcount"},   32'(bus.maxcount),   0);
        check({tag, "_valid"},      32'(bus.valid),      0);
        check({tag, "_new_sample"}, 32'(bus.new_sample), 0);
        check({tag, "_silent"},     32'(bus.silent),     1);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.new_sample) begin
            check("ns_single", 32'(prev_ns), 0);
            if (sb_q.size() == 0) begin
                check("ns_unexpected", 1, 0);
            end else begin
                exp_mc = sb_q.pop_front();
                check("sample_maxcount", 32'(bus.maxcount), exp_mc);
                check("sample_valid",    32'(bus.valid),    1);
            end
        end
        prev_ns = bus.new_sample;
        if (watch_hold && !bus.valid) valid_drops++;
        if (watch_low && bus.valid)   valid_highs++;
    end

    initial begin
        bus.tone_in = 1'b0;
        rst = 1'b1;
        wait_cycles(20);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        wait_cycles(5);
        check_reset_outputs("rst_release");

        // Steady tone, half-period 100
        toggle(10, 0);
        wait_cycles(6);
        check("s2_silent_after_first", 32'(bus.silent), 0);
        check("s2_valid_before_lock",  32'(bus.valid),  0);
        toggle(100, 6);
        toggle(100, 0);
        wait_cycles(6);
        check("s2_valid_locked",    32'(bus.valid),    1);
        check("s2_maxcount_locked", 32'(bus.maxcount), 99);
        toggle(100, 6);
        for (int i = 0; i < 3; i++) toggle(100, 0);
        wait_cycles(10);
        check("s2_drain", sb_q.size(), 0);

        // Switch to half-period 50 while locked
        toggle(50, 10);
        wait_cycles(6);
        check("s3_valid_dropped", 32'(bus.valid),    0);
        check("s3_maxcount_held", 32'(bus.maxcount), 99);
        toggle(50, 6);
        toggle(50, 0);
        toggle(50, 0);
        wait_cycles(10);
        check("s3_valid_relocked", 32'(bus.valid),    1);
        check("s3_maxcount_49",    32'(bus.maxcount), 49);
        check("s3_drain", sb_q.size(), 0);

        // Asynchronous reset while locked
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        bus.tone_in = 1'b0;
        reset_model();
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(5);

        // Alternating 100/101 stays locked
        toggle(10, 0);
        toggle(100, 0);
        toggle(101, 0);
        wait_cycles(6);
        watch_hold = 1'b1;
        toggle(100, 6);
        for (int i = 0; i < 6; i++) toggle((i % 2 == 0) ? 101 : 100, 0);
        wait_cycles(10);
        watch_hold = 1'b0;
        check("s4_valid_held", valid_drops, 0);
        check("s4_drain", sb_q.size(), 0);

        // Alternating 100/110 never locks
        do_reset();
        watch_low = 1'b1;
        toggle(10, 0);
        for (int i = 0; i < 8; i++) toggle((i % 2 == 0) ? 100 : 110, 0);
        wait_cycles(10);
        watch_low = 1'b0;
        check("s5_never_valid", valid_highs, 0);
        check("s5_drain", sb_q.size(), 0);

        // Lock, go silent, time out, then relock at a new pitch
        do_reset();
        toggle(10, 0);
        for (int i = 0; i < 3; i++) toggle(100, 0);
        wait_cycles(65530);
        check("s6_not_yet_silent", 32'(bus.silent), 0);
        check("s6_still_valid",    32'(bus.valid),  1);
        wait_cycles(15);
        check("s6_silent",   32'(bus.silent),   1);
        check("s6_valid",    32'(bus.valid),    0);
        check("s6_maxcount", 32'(bus.maxcount), 0);
        check("s6_drain_pre", sb_q.size(), 0);
        m_state = M_IDLE;
        toggle(200, 0);
        for (int i = 0; i < 3; i++) toggle(200, 0);
        wait_cycles(10);
        check("s6_relock_valid",    32'(bus.valid),    1);
        check("s6_relock_maxcount", 32'(bus.maxcount), 199);
        check("s6_relock_silent",   32'(bus.silent),   0);
        check("s6_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Receive-side counterpart of the speaker tone path: measures an incoming square-wave tone and recovers the divider terminal count that would generate it.
- Team divider convention: output toggles every MAXCOUNT+1 clk cycles, so a measured half-period of P cycles is reported as maxcount = P-1.
- Used for tone loopback self-test of the speaker output and for decoding external tone inputs. The recovered count feeds note-decode logic downstream.

Parameters:
WIDTH, 16, width of the half-period counter and maxcount output; matches the divider MAXCOUNT width.
SYNC_STAGES, 2, number of synchronizer flops on tone_in (minimum 2).
TOL, 2, maximum absolute difference in clk cycles between consecutive half-periods still treated as agreeing.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
tone_in  input  1  asynchronous square-wave tone input.
maxcount  output  WIDTH  recovered terminal count (half-period minus 1); valid only while valid=1.
valid  output  1  high while the detector is locked to a stable tone.
new_sample  output  1  one-cycle pulse each time maxcount is written while locked.
silent  output  1  high when no edge has been seen for 2^WIDTH-1 cycles, and after reset.

Behaviour:
- Reset (async, rst=1):
  - Synchronizer flops and edge-detect history = 0; state = IDLE; cnt = 0; last = 0.
  - maxcount = 0, valid = 0, new_sample = 0, silent = 1.
- Synchronizer and edge detect:
  - tone_in passes through SYNC_STAGES flops. An edge is a difference between the last sync flop and one further history flop; both rising and falling edges count.
  - If tone_in is already 1 at reset release, the resulting rising edge counts as a normal first edge.
- Counter cnt (WIDTH bits):
  - Cleared to 0 on the cycle after an edge, then increments every cycle and saturates at all-ones.
  - On an edge cycle, cnt equals P-1, where P is the clk distance between the two edges.
- FSM; all outputs are registered and update the cycle after the edge-detect cycle:
  - IDLE: on edge -> ARMED; silent <= 0. No edge -> stay.
  - ARMED: on edge -> TRACK; last <= cnt.
  - TRACK: on edge, if |cnt - last| <= TOL -> LOCKED; valid <= 1; maxcount <= cnt; new_sample pulses. Otherwise stay in TRACK. In both cases last <= cnt.
  - LOCKED, edge that agrees: maxcount <= cnt; new_sample pulses; last <= cnt.
  - LOCKED, edge that disagrees: -> TRACK; valid <= 0; maxcount holds; last <= cnt.
  - Any state except IDLE, cnt saturated (2^WIDTH-1) with no edge: -> IDLE; valid <= 0; silent <= 1; maxcount <= 0.
- Difference arithmetic: computed in WIDTH+1 bits as an absolute value, with no wrap.
- Simultaneous edge and saturation: the edge wins. It is processed as a transition from IDLE, i.e. it goes to ARMED.
- Latency: a tone_in transition reaches the edge detector after SYNC_STAGES+1 clk. Outputs follow 1 clk later.
- From the first edge, lock requires a minimum of 3 edges.
- new_sample is never high for two consecutive cycles.
- rst asserted at any time clears everything immediately, with no wait for a clk edge.

Optional Feature:
- Macro: TONE_DETECTOR_AVG_EN.
- Defined: on each agreeing edge (TRACK->LOCKED or LOCKED), maxcount <= (cnt + last) >> 1. The sum is taken at WIDTH+1 bits and rounded down. This hides duty-cycle asymmetry.
- Undefined: maxcount <= cnt (the latest half-period only).
- Lock and unlock rules are identical in both builds.

Test Plan:
1. Reset with tone_in=0, hold 20 clk -> maxcount=0, valid=0, new_sample=0, silent=1; assert rst mid-lock (from scenario 2) -> all outputs return to reset values asynchronously within the same cycle.
2. tone_in toggles every 100 clk -> silent=0 after first edge; valid=1, maxcount=99 after the third edge; new_sample exactly one pulse per subsequent edge.
3. Locked at 99, switch to toggling every 50 clk -> first 50-cycle edge drops valid with maxcount still 99; next edge relocks with maxcount=49.
4. Half-periods alternating 100/101, TOL=2 -> valid stays 1 throughout. Without macro, maxcount alternates 99/100. With TONE_DETECTOR_AVG_EN, maxcount=99 on every update.
5. Half-periods alternating 100/110 -> valid never asserts; new_sample never pulses.
6. Locked tone then tone_in held constant -> exactly 65535 cycles after the last cnt clear, silent=1, valid=0, maxcount=0. Resume toggling every 200 clk -> relock with maxcount=199.
